icache_assoc_mem: RTL
=====================

# icache_assoc_mem

Parametrised set-associative instruction-cache storage array, the successor to the 32-entry direct-mapped, 3-read/1-write cache memory. Holds tag, data and valid state for `NUM_SETS` x `NUM_WAYS` lines and serves `NUM_RD_PORTS` combinational tag-compare lookups per cycle. It also accepts one fill per cycle with automatic victim selection, and runs a multi-cycle flush sequencer. Sits between the icache controller (lookup and fill requests) and the fetch stage (returned instruction data).

## Interface
- `NUM_SETS`, 16, number of sets, power of two ≥2; `IDX_W = $clog2(NUM_SETS)`
- `NUM_WAYS`, 2, ways per set, power of two ≥2; `WAY_W = $clog2(NUM_WAYS)`
- `NUM_RD_PORTS`, 3, independent lookup ports
- `TAG_W`, 8, tag width
- `DATA_W`, 64, line data width
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `rd_index`  in  `[NUM_RD_PORTS][IDX_W]`  lookup set index per port
- `rd_tag`  in  `[NUM_RD_PORTS][TAG_W]`  lookup tag per port
- `rd_en`  in  `[NUM_RD_PORTS]`  port active; an inactive port reports miss and causes no replacement-state update
- `rd_hit`  out  `[NUM_RD_PORTS]`  tag match on a valid way
- `rd_way`  out  `[NUM_RD_PORTS][WAY_W]`  hitting way; 0 on miss
- `rd_data`  out  `[NUM_RD_PORTS][DATA_W]`  hitting line data; 0 on miss
- `wr_en`  in  1  fill request
- `wr_index`  in  `IDX_W`  fill set
- `wr_tag`  in  `TAG_W`  fill tag
- `wr_data`  in  `DATA_W`  fill data
- `wr_ready`  out  1  fill accepted this cycle; equals `!flush_busy`
- `wr_way`  out  `WAY_W`  way the fill will occupy (combinational)
- `flush_req`  in  1  start flush sequence
- `flush_busy`  out  1  flush in progress
- `flush_done`  out  1  one-cycle pulse on flush completion

## Operation
- Lookup is combinational against current-cycle state. The hit is the valid way whose stored tag equals `rd_tag`. Because fills never duplicate a tag in a set, at most one way matches.
- Fill victim selection, evaluated in the fill cycle, in priority order:
  - the way already holding `wr_tag` (update in place);
  - otherwise the lowest-numbered invalid way;
  - otherwise the replacement-policy victim.
- A fill with `wr_en && wr_ready` writes data, tag and valid=1 into `wr_way` at the clock edge. With `wr_en && !wr_ready` the fill is dropped, with no state change.
- The replacement state is updated at the edge by each active hitting read port, in ascending port order, then by an accepted fill (marks `wr_way` most recently used). Later updates override earlier ones on contested bits.
- Flush FSM:
  - IDLE: on `flush_req`, go to FLUSH with counter = 0.
  - FLUSH: clear all valids and the replacement state of set `counter`, then increment. After clearing set `NUM_SETS-1`, return to IDLE and pulse `flush_done` in that cycle.
  - `flush_req` during FLUSH is ignored.
  - During FLUSH all `rd_hit` = 0 and fills are refused.
- Reset values: all valids 0, replacement state 0, FSM IDLE, counter 0. Resulting outputs: `rd_hit` 0, `rd_way` 0, `rd_data` 0, `wr_ready` 1, `flush_busy` 0, `flush_done` 0. Data and tag arrays are not reset.

## Timing
- Lookup latency 0 cycles. A fill is visible to lookups from the cycle after its accepting edge; a same-cycle read returns the pre-fill contents.
- Flush occupies exactly `NUM_SETS` cycles with `flush_busy` = 1. `flush_done` is asserted for 1 cycle, coincident with the last FLUSH cycle. `wr_ready` returns to 1 on the following cycle.
- `flush_req` and `wr_en` in the same IDLE cycle: the fill is accepted, and the flush starts on the next cycle and erases it.
- `rst_n` asserted mid-flush: immediate return to IDLE, all valids cleared, no `flush_done`.
- Counter wrap: the counter is `IDX_W` bits; its wrap back to 0 coincides with the FLUSH→IDLE transition.

## Configuration
- `ICACHE_PLRU_EN` defined: tree pseudo-LRU, `NUM_WAYS-1` bits per set. Updated by read hits and by fills as described above.
- Undefined: per-set round-robin pointer (`WAY_W` bits). The victim is the pointer value. The pointer advances by 1 (mod `NUM_WAYS`) only on accepted fills that replace a valid line; read hits have no effect.

## Structure
- Shared package `icache_pkg`: default parameter constants, the flush-state enum (`IDLE`, `FLUSH`) and a line struct {valid, tag, data}.
- One sub-module, `icache_repl`: holds the per-set replacement state (PLRU tree or round-robin pointer, selected by the macro). Inputs: touch vectors and set clear. Outputs: the victim way for the fill set.

## Test plan
- Defaults. Fill set 3, tag 0x12, data 0xA5 → on the next cycle port 0 lookup (3, 0x12) gives `rd_hit`=1, `rd_way`=0, `rd_data`=0xA5. Port 1 lookup (3, 0x13) gives miss, data 0.
- Fill tags 0x10, 0x20, 0x30 into set 5 with no reads in between. PLRU defined: the third fill evicts way 0 (0x10); round-robin: same. Then read-hit 0x20 (way 1) and fill 0x40. PLRU: 0x30 evicted; round-robin: way 1 (0x20) evicted.
- All three ports look up the same set in the cycle a fill targets it → reads show old contents, then the new line on the next cycle.
- Re-fill an existing tag 0x12 in set 3 with data 0xFF → same way is overwritten, other way untouched, no duplicate hit.
- Fill 16 sets, pulse `flush_req` → `flush_busy` for 16 cycles, `flush_done` in cycle 16, a `wr_en` during the flush is dropped, and all lookups miss afterwards.
- Assert `rst_n` at flush cycle 7 → FSM returns to IDLE, no `flush_done`, `wr_ready` = 1, all sets miss.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared constants and types for the set-associative icache storage array.
// Replacement policy selected by ICACHE_PLRU_EN (tree PLRU) or its absence (round-robin).
package icache_pkg;

  localparam int ICACHE_NUM_SETS     = 16;
  localparam int ICACHE_NUM_WAYS     = 2;
  localparam int ICACHE_NUM_RD_PORTS = 3;
  localparam int ICACHE_TAG_W        = 8;
  localparam int ICACHE_DATA_W       = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_e;

  typedef struct packed {
    logic                     valid;
    logic [ICACHE_TAG_W-1:0]  tag;
    logic [ICACHE_DATA_W-1:0] data;
  } icache_line_t;

endpackage

// File: rtl/icache_repl.sv
// Per-set replacement state: tree pseudo-LRU when ICACHE_PLRU_EN is defined,
// otherwise a round-robin pointer that advances only when a valid line is evicted.
module icache_repl
  import icache_pkg::*;
#(
  parameter  int NUM_SETS     = ICACHE_NUM_SETS,
  parameter  int NUM_WAYS     = ICACHE_NUM_WAYS,
  parameter  int NUM_RD_PORTS = ICACHE_NUM_RD_PORTS,
  localparam int IDX_W        = $clog2(NUM_SETS),
  localparam int WAY_W        = $clog2(NUM_WAYS)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_RD_PORTS-1:0]              rd_touch,
  input  logic [NUM_RD_PORTS-1:0][IDX_W-1:0]   rd_touch_idx,
  input  logic [NUM_RD_PORTS-1:0][WAY_W-1:0]   rd_touch_way,
  input  logic                                 fill_touch,
  input  logic                                 fill_replace,
  input  logic [IDX_W-1:0]                     fill_idx,
  input  logic [WAY_W-1:0]                     fill_way,
  input  logic                                 clr_en,
  input  logic [IDX_W-1:0]                     clr_idx,
  output logic [WAY_W-1:0]                     victim_way
);

`ifdef ICACHE_PLRU_EN
  localparam int TREE_W = NUM_WAYS - 1;

  logic [TREE_W-1:0] tree_q [NUM_SETS];
  logic [TREE_W-1:0] tree_d [NUM_SETS];
  logic              fill_unused;

  // Node n has children 2n+1 (left, lower ways) and 2n+2; a set bit points right.
  function automatic logic [TREE_W-1:0] plru_touch(input logic [TREE_W-1:0] t,
                                                   input logic [WAY_W-1:0]  w);
    logic [TREE_W-1:0] r;
    int                node;
    r    = t;
    node = 0;
    for (int l = WAY_W - 1; l >= 0; l--) begin
      r    = (r & ~(TREE_W'(1) << node)) | (TREE_W'(!w[l]) << node);
      node = 2 * node + (w[l] ? 2 : 1);
    end
    return r;
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input logic [TREE_W-1:0] t);
    logic [WAY_W-1:0]  v;
    logic [TREE_W-1:0] sh;
    int                node;
    v    = '0;
    node = 0;
    for (int l = WAY_W - 1; l >= 0; l--) begin
      sh   = t >> node;
      v[l] = sh[0];
      node = 2 * node + (sh[0] ? 2 : 1);
    end
    return v;
  endfunction

  always_comb begin
    tree_d = tree_q;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      if (rd_touch[p]) begin
        tree_d[rd_touch_idx[p]] = plru_touch(tree_d[rd_touch_idx[p]], rd_touch_way[p]);
      end
    end
    if (fill_touch) tree_d[fill_idx] = plru_touch(tree_d[fill_idx], fill_way);
    if (clr_en) tree_d[clr_idx] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) tree_q[s] <= '0;
    end else begin
      tree_q <= tree_d;
    end
  end

  assign victim_way  = plru_victim(tree_q[fill_idx]);
  assign fill_unused = fill_replace;
`else
  logic [WAY_W-1:0] ptr_q [NUM_SETS];
  logic [WAY_W-1:0] ptr_d [NUM_SETS];
  logic             rd_unused;

  always_comb begin
    ptr_d = ptr_q;
    if (fill_touch && fill_replace) ptr_d[fill_idx] = ptr_q[fill_idx] + WAY_W'(1);
    if (clr_en) ptr_d[clr_idx] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) ptr_q[s] <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign victim_way = ptr_q[fill_idx];
  assign rd_unused  = ^{rd_touch, rd_touch_idx, rd_touch_way, fill_way};
`endif

endmodule

// File: rtl/icache_assoc_mem.sv
// Set-associative icache tag/data/valid array with combinational multi-port lookup,
// single-port fill with victim selection, and a one-set-per-cycle flush sequencer.
module icache_assoc_mem
  import icache_pkg::*;
#(
  parameter  int NUM_SETS     = ICACHE_NUM_SETS,
  parameter  int NUM_WAYS     = ICACHE_NUM_WAYS,
  parameter  int NUM_RD_PORTS = ICACHE_NUM_RD_PORTS,
  parameter  int TAG_W        = ICACHE_TAG_W,
  parameter  int DATA_W       = ICACHE_DATA_W,
  localparam int IDX_W        = $clog2(NUM_SETS),
  localparam int WAY_W        = $clog2(NUM_WAYS)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_RD_PORTS-1:0][IDX_W-1:0]    rd_index,
  input  logic [NUM_RD_PORTS-1:0][TAG_W-1:0]    rd_tag,
  input  logic [NUM_RD_PORTS-1:0]               rd_en,
  output logic [NUM_RD_PORTS-1:0]               rd_hit,
  output logic [NUM_RD_PORTS-1:0][WAY_W-1:0]    rd_way,
  output logic [NUM_RD_PORTS-1:0][DATA_W-1:0]   rd_data,
  input  logic                                  wr_en,
  input  logic [IDX_W-1:0]                      wr_index,
  input  logic [TAG_W-1:0]                      wr_tag,
  input  logic [DATA_W-1:0]                     wr_data,
  output logic                                  wr_ready,
  output logic [WAY_W-1:0]                      wr_way,
  input  logic                                  flush_req,
  output logic                                  flush_busy,
  output logic                                  flush_done
);

  flush_state_e      state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
  logic [TAG_W-1:0]  tag_q  [NUM_SETS][NUM_WAYS];
  logic [DATA_W-1:0] data_q [NUM_SETS][NUM_WAYS];

  logic              fill_acc, fill_replace;
  logic              match_found, inv_found;
  logic [WAY_W-1:0]  match_way, inv_way, victim_way, fill_way;

  always_comb begin
    rd_hit  = '0;
    rd_way  = '0;
    rd_data = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (rd_en[p] && !busy_q && valid_q[rd_index[p]][w] &&
            tag_q[rd_index[p]][w] == rd_tag[p]) begin
          rd_hit[p]  = 1'b1;
          rd_way[p]  = WAY_W'(w);
          rd_data[p] = data_q[rd_index[p]][w];
        end
      end
    end
  end

  // Victim priority: same tag in place, then lowest invalid way, then policy choice.
  always_comb begin
    match_found = 1'b0;
    match_way   = '0;
    inv_found   = 1'b0;
    inv_way     = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!match_found && valid_q[wr_index][w] && tag_q[wr_index][w] == wr_tag) begin
        match_found = 1'b1;
        match_way   = WAY_W'(w);
      end
      if (!inv_found && !valid_q[wr_index][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    if (match_found)    fill_way = match_way;
    else if (inv_found) fill_way = inv_way;
    else                fill_way = victim_way;
  end

  assign fill_acc     = wr_en && !busy_q;
  assign fill_replace = !match_found && !inv_found;
  assign wr_way       = fill_way;
  assign wr_ready     = !busy_q;
  assign flush_busy   = busy_q;
  assign flush_done   = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (fill_acc) valid_d[wr_index][fill_way] = 1'b1;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        valid_d[cnt_q] = '0;
        cnt_d          = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(NUM_SETS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered, so decode them from the upcoming state.
    busy_d = (state_d == FLUSH);
    done_d = (state_d == FLUSH) && (cnt_d == IDX_W'(NUM_SETS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_acc) begin
      tag_q[wr_index][fill_way]  <= wr_tag;
      data_q[wr_index][fill_way] <= wr_data;
    end
  end

  icache_repl #(
    .NUM_SETS     (NUM_SETS),
    .NUM_WAYS     (NUM_WAYS),
    .NUM_RD_PORTS (NUM_RD_PORTS)
  ) u_repl (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_touch     (rd_hit),
    .rd_touch_idx (rd_index),
    .rd_touch_way (rd_way),
    .fill_touch   (fill_acc),
    .fill_replace (fill_replace),
    .fill_idx     (wr_index),
    .fill_way     (fill_way),
    .clr_en       (state_q == FLUSH),
    .clr_idx      (cnt_q),
    .victim_way   (victim_way)
  );

endmodule
